// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-domain drain controller for ASYNC_FIFO.
// Pops a programmed burst and streams it on valid/ready/last through a 2-entry skid buffer.
//
// state    | meaning
// ST_IDLE  | waiting for start, burst length latched on accept
// ST_READ  | issuing pops until the issue count reaches the length
// ST_DRAIN | all pops issued, emptying skid buffer to the sink
// ST_DONE  | one-cycle completion pulse
module fifo_rd_streamer #(
   parameter int DATA_SIZE = 12,
   parameter int LEN_W     = 8
) (
   input  logic                 rclk,
   input  logic                 rrst,
   input  logic                 start,
   input  logic [LEN_W-1:0]     len,
   output logic                 busy,
   output logic                 done,
   output logic                 rinc,
   input  logic                 rEmpty,
   input  logic [DATA_SIZE-1:0] rData,
   output logic [DATA_SIZE-1:0] oData,
   output logic                 oValid,
   input  logic                 oReady,
   output logic                 oLast
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

   state_t               state_q, state_d;
   logic [LEN_W-1:0]     len_q, len_d;
   logic [LEN_W-1:0]     issued_q, issued_d;
   logic [LEN_W-1:0]     delivered_q, delivered_d;
   logic                 pend_q, pend_d;
   logic [1:0]           occ_q, occ_d;
   logic [DATA_SIZE-1:0] head_q, head_d;
   logic [DATA_SIZE-1:0] tail_q, tail_d;
   logic                 busy_q, done_q;
   logic                 pop;
   logic [2:0]           fill;

   assign pop    = oValid && oReady;
   // Words buffered plus in flight after this cycle's pop; a new pop must keep this below 2.
   assign fill   = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
   assign rinc   = (state_q == ST_READ) && !rEmpty && (issued_q < len_q) && (fill < 3'd2);
   assign oValid = (occ_q != 2'd0);
   assign oData  = head_q;
   assign oLast  = oValid && (delivered_q == len_q - LEN_W'(1));
   assign busy   = busy_q;
   assign done   = done_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      issued_d    = issued_q;
      delivered_d = delivered_q;
      pend_d      = rinc;
      occ_d       = occ_q;
      head_d      = head_q;
      tail_d      = tail_q;

      if (rinc) issued_d = issued_q + LEN_W'(1);
      if (pop)  delivered_d = delivered_q + LEN_W'(1);

      // pend_q marks the cycle in which rData carries the word popped last cycle.
      case ({pend_q, pop})
         2'b10: begin
            if (occ_q == 2'd0) head_d = rData;
            else               tail_d = rData;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = rData;
            end else begin
               head_d = tail_q;
               tail_d = rData;
            end
         end
         default: ;
      endcase

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d       = len;
               issued_d    = '0;
               delivered_d = '0;
               state_d     = (len == '0) ? ST_DONE : ST_READ;
            end
         end
         ST_READ: begin
            if (rinc && (issued_d == len_q)) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pop && oLast) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge rclk or posedge rrst) begin
      if (rrst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         issued_q    <= '0;
         delivered_q <= '0;
         pend_q      <= 1'b0;
         occ_q       <= 2'd0;
         head_q      <= '0;
         tail_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         issued_q    <= issued_d;
         delivered_q <= delivered_d;
         pend_q      <= pend_d;
         occ_q       <= occ_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         busy_q      <= (state_d == ST_READ) || (state_d == ST_DRAIN);
         done_q      <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based FIFO and burst model checked every cycle,
// plus directed bursts with hand-computed cycle traces.
module tb_fifo_rd_streamer;
   localparam int DW = 12;
   localparam int LW = 8;

   logic          rclk   = 1'b0;
   logic          rrst   = 1'b1;
   logic          start  = 1'b0;
   logic [LW-1:0] len    = '0;
   logic          rEmpty = 1'b1;
   logic [DW-1:0] rData  = '0;
   logic          oReady = 1'b0;
   logic          busy, done, rinc, oValid, oLast;
   logic [DW-1:0] oData;

   int n_checks = 0;
   int n_errors = 0;

   int   fifo_q[$];
   int   exp_q[$];
   int   fw;
   logic rinc_s = 1'b0;
   logic hs;
   int   m_phase = 0, m_len = 0, m_issued = 0, m_deliv = 0;

   logic [63:0] tr_rinc, tr_valid, tr_last, tr_done, tr_busy;
   int   hs_data[$];
   int   hs_cyc[$];
   int   n_done, last_idx, n_rinc_empty;

   fifo_rd_streamer #(.DATA_SIZE(DW), .LEN_W(LW)) dut (
      .rclk   (rclk),
      .rrst   (rrst),
      .start  (start),
      .len    (len),
      .busy   (busy),
      .done   (done),
      .rinc   (rinc),
      .rEmpty (rEmpty),
      .rData  (rData),
      .oData  (oData),
      .oValid (oValid),
      .oReady (oReady),
      .oLast  (oLast)
   );

   always #5 rclk = ~rclk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // FIFO with registered empty flag and one-cycle read latency; popped words go to the scoreboard.
   always @(posedge rclk) begin
      if (rinc_s && !rrst && fifo_q.size() != 0) begin
         fw = fifo_q.pop_front();
         rData <= DW'(fw);
         exp_q.push_back(fw);
      end
      rEmpty <= (fifo_q.size() == 0);
   end

   // Burst model: in-order word delivery, last flag on word len-1, busy until the final
   // handshake, done in the following cycle, at most 2 words buffered or in flight.
   always @(negedge rclk) begin
      rinc_s = rinc;
      if (rrst) begin
         m_phase  = 0;
         m_issued = 0;
         m_deliv  = 0;
         exp_q.delete();
      end else begin
         check("busy", busy, m_phase == 1);
         check("done", done, m_phase == 2);
         check("rinc_when_empty", rinc && rEmpty, 0);
         check("rinc_outside_burst", rinc && (m_phase != 1), 0);
         hs = oValid && oReady;
         if (oValid) begin
            check("valid_has_word", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("oData", oData, exp_q[0]);
         end
         check("oLast", oLast, oValid && (m_deliv == m_len - 1));
         if (rinc) m_issued++;
         if (hs) begin
            m_deliv++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         check("in_flight_bound", (m_issued - m_deliv) <= 2, 1);
         check("issue_bound", m_issued <= m_len, 1);
         case (m_phase)
            0: if (start) begin
               m_len    = int'(len);
               m_issued = 0;
               m_deliv  = 0;
               m_phase  = (len == '0) ? 2 : 1;
            end
            1: if (hs && m_deliv == m_len) m_phase = 2;
            default: m_phase = 0;
         endcase
      end
   end

   task automatic step();
      @(posedge rclk);
      #1;
   endtask

   task automatic clear_trace();
      tr_rinc = '0; tr_valid = '0; tr_last = '0; tr_done = '0; tr_busy = '0;
      hs_data.delete();
      hs_cyc.delete();
      n_done = 0;
      last_idx = -1;
      n_rinc_empty = 0;
   endtask

   task automatic sample(input int k);
      @(negedge rclk);
      tr_rinc[k]  = rinc;
      tr_valid[k] = oValid;
      tr_last[k]  = oLast;
      tr_done[k]  = done;
      tr_busy[k]  = busy;
      if (rinc && rEmpty) n_rinc_empty++;
      if (oValid && oReady) begin
         if (oLast) last_idx = hs_data.size();
         hs_data.push_back(int'(oData));
         hs_cyc.push_back(k);
      end
      if (done) n_done++;
   endtask

   task automatic load_fifo(input int base, input int n);
      fifo_q.delete();
      for (int i = 0; i < n; i++) fifo_q.push_back(base + i);
      step();
      step();
   endtask

   task automatic check_stream(input string name, input int base, input int n);
      check({name, "_count"}, hs_data.size(), n);
      for (int i = 0; i < n && i < hs_data.size(); i++)
         check({name, "_data"}, hs_data[i], base + i);
   endtask

   int bad_hold;

   initial begin
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rinc", rinc, 0);
      check("rst_oValid", oValid, 0);
      check("rst_oLast", oLast, 0);
      check("rst_oData", oData, 0);
      repeat (3) @(posedge rclk);
      #1 rrst = 1'b0;

      // Basic burst of 3
      oReady = 1'b1;
      load_fifo(1, 3);
      start = 1'b1; len = 8'd3;
      clear_trace();
      for (int k = 1; k <= 8; k++) begin
         step();
         start = 1'b0;
         sample(k);
      end
      check("basic_rinc",  int'(tr_rinc[8:0]),  9'b000001110);
      check("basic_valid", int'(tr_valid[8:0]), 9'b000111000);
      check("basic_last",  int'(tr_last[8:0]),  9'b000100000);
      check("basic_done",  int'(tr_done[8:0]),  9'b001000000);
      check("basic_busy",  int'(tr_busy[8:0]),  9'b000111110);
      check_stream("basic", 1, 3);
      if (hs_cyc.size() == 3) begin
         check("basic_hs0_cycle", hs_cyc[0], 3);
         check("basic_hs2_cycle", hs_cyc[2], 5);
      end

      // Zero length
      start = 1'b1; len = 8'd0;
      clear_trace();
      for (int k = 1; k <= 4; k++) begin
         step();
         start = 1'b0;
         sample(k);
      end
      check("zero_done", int'(tr_done[4:0]), 5'b00010);
      check("zero_busy", int'(tr_busy[4:0]), 0);
      check("zero_rinc", int'(tr_rinc[4:0]), 0);

      // Sink backpressure for 10 cycles
      oReady = 1'b0;
      load_fifo(12'h100, 8);
      start = 1'b1; len = 8'd8;
      clear_trace();
      bad_hold = 0;
      for (int k = 1; k <= 24; k++) begin
         step();
         start = 1'b0;
         oReady = (k >= 11);
         sample(k);
         if (k >= 3 && k <= 10 && (!oValid || oData != 12'h100)) bad_hold++;
      end
      check("bp_rinc_in_stall", $countones(tr_rinc[10:1]), 2);
      check("bp_hold_word0", bad_hold, 0);
      check_stream("bp", 12'h100, 8);
      for (int i = 0; i < hs_cyc.size(); i++) check("bp_hs_cycle", hs_cyc[i], 11 + i);
      check("bp_last_idx", last_idx, 7);
      check("bp_done_cycle", int'(tr_done[19]), 1);
      check("bp_done_count", n_done, 1);

      // FIFO empty mid-burst
      oReady = 1'b1;
      load_fifo(12'h200, 2);
      start = 1'b1; len = 8'd4;
      clear_trace();
      for (int k = 1; k <= 32; k++) begin
         step();
         start = 1'b0;
         if (k == 20) begin
            fifo_q.push_back(12'h202);
            fifo_q.push_back(12'h203);
         end
         sample(k);
      end
      check("empty_rinc_when_empty", n_rinc_empty, 0);
      check_stream("empty", 12'h200, 4);
      if (hs_cyc.size() == 4) begin
         check("empty_hs1_cycle", hs_cyc[1], 4);
         check("empty_hs2_cycle", hs_cyc[2], 23);
         check("empty_hs3_cycle", hs_cyc[3], 24);
      end
      check("empty_last_idx", last_idx, 3);
      check("empty_done_count", n_done, 1);
      check("empty_done_cycle", int'(tr_done[25]), 1);

      // Start ignored while busy
      load_fifo(12'h300, 8);
      start = 1'b1; len = 8'd3;
      clear_trace();
      for (int k = 1; k <= 16; k++) begin
         step();
         start = (k == 2);
         if (k == 2) len = 8'd5;
         sample(k);
      end
      check_stream("ign", 12'h300, 3);
      check("ign_rinc_count", $countones(tr_rinc[16:1]), 3);
      check("ign_last_idx", last_idx, 2);
      check("ign_done_count", n_done, 1);

      // Asynchronous reset after the 2nd handshake of a 6-word burst
      load_fifo(12'h400, 6);
      start = 1'b1; len = 8'd6;
      clear_trace();
      for (int k = 1; k <= 4; k++) begin
         step();
         start = 1'b0;
         sample(k);
      end
      check("rstb_hs_before", hs_data.size(), 2);
      step();
      #2 rrst = 1'b1;
      #1;
      check("rstb_busy", busy, 0);
      check("rstb_done", done, 0);
      check("rstb_rinc", rinc, 0);
      check("rstb_oValid", oValid, 0);
      check("rstb_oLast", oLast, 0);
      check("rstb_oData", oData, 0);
      clear_trace();
      for (int k = 1; k <= 6; k++) begin
         step();
         if (k == 2) rrst = 1'b0;
         sample(k);
      end
      check("rstb_no_done", n_done, 0);
      check("rstb_no_busy", int'(tr_busy[6:0]), 0);

      load_fifo(12'h0AB, 1);
      start = 1'b1; len = 8'd1;
      clear_trace();
      for (int k = 1; k <= 6; k++) begin
         step();
         start = 1'b0;
         sample(k);
      end
      check_stream("post", 12'h0AB, 1);
      check("post_last_idx", last_idx, 0);
      check("post_rinc", int'(tr_rinc[6:0]), 7'b0000010);
      check("post_done", int'(tr_done[6:0]), 7'b0010000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
